// File: rtl/round_robin_arbiter.sv
// Registered N-way round-robin arbiter with hold-until-release ownership.
// Define RR_ARBITER_HOLD_LIMIT_EN to add MAX_HOLD-cycle preemption when others wait.
module round_robin_arbiter #(
  parameter int unsigned N        = 5,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         requests,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_index,
  output logic                 preempted
);

  localparam int unsigned IW = $clog2(N);

  if (N < 2 || N > 32) begin : g_bad_n
    $error("round_robin_arbiter: N must be in 2..32");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("round_robin_arbiter: MAX_HOLD must be in 1..255");
  end

  typedef enum logic {StIdle, StOwned} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic          valid_q, valid_d;
  logic [IW-1:0] index_q, index_d;
  logic [IW-1:0] last_q, last_d;
  logic          pre_q, pre_d;

  logic          owner_req;
  logic          preempt_now;
  logic          take;
  logic [N-1:0]  arb_req;
  logic          arb_found;
  logic [IW-1:0] arb_idx;

  assign owner_req = |(requests & grant_q);

`ifdef RR_ARBITER_HOLD_LIMIT_EN
  logic [7:0] hold_q, hold_d;

  assign preempt_now = (state_q == StOwned) && (hold_q == 8'(MAX_HOLD)) && owner_req &&
                       (|(requests & ~grant_q));

  // Counter reads 1 during the first owned cycle, so the owner gets exactly MAX_HOLD cycles.
  always_comb begin
    hold_d = hold_q;
    if (take) begin
      hold_d = 8'd1;
    end else if (state_d == StIdle) begin
      hold_d = '0;
    end else if (hold_q != 8'(MAX_HOLD)) begin
      hold_d = hold_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign preempt_now = 1'b0;
`endif

  // A preempted owner is masked out; a released owner already has its bit low.
  assign arb_req = preempt_now ? (requests & ~grant_q) : requests;

  // Search last+1 .. N-1 first, then wrap to 0 .. last, so the last owner comes last.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int j = 0; j < N; j++) begin
      if (!arb_found && arb_req[j] && (j > int'(last_q))) begin
        arb_found = 1'b1;
        arb_idx   = IW'(j);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!arb_found && arb_req[j] && (j <= int'(last_q))) begin
        arb_found = 1'b1;
        arb_idx   = IW'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    valid_d = valid_q;
    index_d = index_q;
    last_d  = last_q;
    pre_d   = 1'b0;
    take    = 1'b0;
    case (state_q)
      StIdle: take = arb_found;
      StOwned: begin
        if (preempt_now) begin
          take = 1'b1;
        end else if (!owner_req) begin
          take = arb_found;
          if (!arb_found) begin
            state_d = StIdle;
            grant_d = '0;
            valid_d = 1'b0;
            index_d = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (take) begin
      state_d          = StOwned;
      grant_d          = '0;
      grant_d[arb_idx] = 1'b1;
      valid_d          = 1'b1;
      index_d          = arb_idx;
      last_d           = arb_idx;
      pre_d            = preempt_now;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      valid_q <= 1'b0;
      index_q <= '0;
      last_q  <= IW'(N - 1);
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      index_q <= index_d;
      last_q  <= last_d;
      pre_q   <= pre_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_index = index_q;
  assign preempted   = pre_q;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Bench for round_robin_arbiter: directed table (N=5, MAX_HOLD=4), hold/reset sequences,
// and a randomized invariant run on an N=7 instance.
module tb_round_robin_arbiter;

  localparam int unsigned N7 = 7;
  localparam int unsigned H7 = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] req5;
  logic [4:0] gnt5;
  logic       valid5;
  logic [2:0] idx5;
  logic       pre5;

  logic [6:0] req7;
  logic [6:0] gnt7;
  logic       valid7;
  logic [2:0] idx7;
  logic       pre7;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  round_robin_arbiter #(.N(5), .MAX_HOLD(4)) dut5 (
    .clk        (clk),
    .reset      (reset),
    .requests   (req5),
    .grant      (gnt5),
    .grant_valid(valid5),
    .grant_index(idx5),
    .preempted  (pre5)
  );

  round_robin_arbiter #(.N(N7), .MAX_HOLD(H7)) dut7 (
    .clk        (clk),
    .reset      (reset),
    .requests   (req7),
    .grant      (gnt7),
    .grant_valid(valid7),
    .grant_index(idx7),
    .preempted  (pre7)
  );

  typedef struct packed {
    logic [4:0] req;
    logic [4:0] gnt;
    logic [2:0] idx;
  } vec_t;

  vec_t tbl [22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check5(input string name, input logic [4:0] g, input logic [2:0] i,
                        input logic p);
    check({name, ".grant"}, 32'(gnt5), 32'(g));
    check({name, ".valid"}, 32'(valid5), 32'(|g));
    check({name, ".index"}, 32'(idx5), 32'(i));
    check({name, ".preempted"}, 32'(pre5), 32'(p));
  endtask

  initial begin
    logic [6:0]  used;
    logic [6:0]  pg;
    logic [6:0]  exp_vec;
    logic [31:0] rnd;
    int          wait7 [N7];

    tbl[0]  = '{5'b10110, 5'b00010, 3'd1};
    tbl[1]  = '{5'b10110, 5'b00010, 3'd1};
    tbl[2]  = '{5'b10100, 5'b00100, 3'd2};
    tbl[3]  = '{5'b10000, 5'b10000, 3'd4};
    tbl[4]  = '{5'b10001, 5'b10000, 3'd4};
    tbl[5]  = '{5'b00001, 5'b00001, 3'd0};
    tbl[6]  = '{5'b00000, 5'b00000, 3'd0};
    tbl[7]  = '{5'b00000, 5'b00000, 3'd0};
    tbl[8]  = '{5'b01000, 5'b01000, 3'd3};
    tbl[9]  = '{5'b00100, 5'b00100, 3'd2};
    tbl[10] = '{5'b00110, 5'b00100, 3'd2};
    tbl[11] = '{5'b00010, 5'b00010, 3'd1};
    tbl[12] = '{5'b11111, 5'b00010, 3'd1};
    tbl[13] = '{5'b11101, 5'b00100, 3'd2};
    tbl[14] = '{5'b11011, 5'b01000, 3'd3};
    tbl[15] = '{5'b00000, 5'b00000, 3'd0};
    tbl[16] = '{5'b00001, 5'b00001, 3'd0};
    tbl[17] = '{5'b00000, 5'b00000, 3'd0};
    tbl[18] = '{5'b00001, 5'b00001, 3'd0};
    tbl[19] = '{5'b00011, 5'b00001, 3'd0};
    tbl[20] = '{5'b00010, 5'b00010, 3'd1};
    tbl[21] = '{5'b00000, 5'b00000, 3'd0};

    reset = 1'b1;
    req5  = '0;
    req7  = '0;
    #3;
    check5("reset", 5'b00000, 3'd0, 1'b0);
    check("reset.grant7", 32'(gnt7), 32'd0);
    #9 reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      req5 = tbl[i].req;
      step();
      check5($sformatf("row%0d", i), tbl[i].gnt, tbl[i].idx, 1'b0);
    end

    // Owner 3 contends with channel 0 (last=1, so 3 wins first).
    req5 = 5'b01001;
`ifdef RR_ARBITER_HOLD_LIMIT_EN
    for (int i = 0; i < 4; i++) begin
      step();
      check5($sformatf("hold%0d", i), 5'b01000, 3'd3, 1'b0);
    end
    step();
    check5("preempt", 5'b00001, 3'd0, 1'b1);
    step();
    check5("after_preempt", 5'b00001, 3'd0, 1'b0);
`else
    for (int i = 0; i < 8; i++) begin
      step();
      check5($sformatf("hold%0d", i), 5'b01000, 3'd3, 1'b0);
    end
`endif
    req5 = 5'b00000;
    step();
    check5("release_idle", 5'b00000, 3'd0, 1'b0);

    // Lone owner keeps the grant past any hold limit.
    req5 = 5'b01000;
    for (int i = 0; i < 10; i++) begin
      step();
      check5($sformatf("alone%0d", i), 5'b01000, 3'd3, 1'b0);
    end

    // Asynchronous reset while owned, then channel 0 has first priority.
    #2 reset = 1'b1;
    #1;
    check5("async_reset", 5'b00000, 3'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    req5  = 5'b11111;
    step();
    check5("post_reset_all", 5'b00001, 3'd0, 1'b0);
    req5 = 5'b00000;

    // Randomized invariants on the N=7 instance.
    for (int c = 0; c < N7; c++) wait7[c] = 0;
    pg = gnt7;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rnd  = $urandom & $urandom;
      req7 = req7 ^ rnd[6:0];
      used = req7;
      step();
      check("r.onehot", 32'($onehot0(gnt7)), 32'd1);
      check("r.valid", 32'(valid7), 32'(|gnt7));
      exp_vec = valid7 ? (7'b1 << idx7) : 7'b0;
      check("r.index", 32'(gnt7), 32'(exp_vec));
      check("r.unrequested", 32'(gnt7 & ~used), 32'd0);
      if ((pg & used) != 7'b0) begin
`ifdef RR_ARBITER_HOLD_LIMIT_EN
        check("r.keep", 32'((gnt7 == pg) || pre7), 32'd1);
`else
        check("r.keep", 32'(gnt7), 32'(pg));
`endif
      end else begin
        check("r.handoff", 32'(valid7), 32'(|used));
      end
`ifdef RR_ARBITER_HOLD_LIMIT_EN
      if (pre7) begin
        check("r.preempt_cause", 32'(((pg & used) != 7'b0) && (gnt7 != pg)), 32'd1);
      end
      for (int c = 0; c < N7; c++) begin
        wait7[c] = (used[c] && !gnt7[c]) ? wait7[c] + 1 : 0;
      end
      for (int c = 0; c < N7; c++) begin
        check($sformatf("r.starve%0d", c), 32'(wait7[c] <= int'((N7 - 1) * H7 + 2)), 32'd1);
      end
`else
      check("r.no_preempt", 32'(pre7), 32'd0);
`endif
      pg = gnt7;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
